// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and counter sizing helper.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2,
        ST_FIX  = 2'd3
    } mul_state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mul_seq_dp.sv
// Datapath of mul_seq: operand, accumulator and product registers plus the
// adder. MUL_SIGNED_EN adds magnitude capture at load and a final negate.
module mul_seq_dp
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
`ifdef MUL_SIGNED_EN
    input  logic               fix_i,
`else
    input  logic               last_i,
`endif
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] p_o
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
`ifdef MUL_SIGNED_EN
    logic               neg_q, neg_d;
`endif

    // Operand capture, one shift-add iteration per step, product registration
    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        p_d      = p_q;
`ifdef MUL_SIGNED_EN
        neg_d    = neg_q;
        a_mag_s  = a_i[WIDTH-1] ? ({WIDTH{1'b0}} - a_i) : a_i;
        b_mag_s  = b_i[WIDTH-1] ? ({WIDTH{1'b0}} - b_i) : b_i;
`else
        a_mag_s  = a_i;
        b_mag_s  = b_i;
`endif
        // carry lands in sum_s[WIDTH] and is shifted into the top of acc
        sum_s = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        if (load_i) begin
            mcand_d  = a_mag_s;
            mplier_d = b_mag_s;
            acc_d    = {WIDTH{1'b0}};
`ifdef MUL_SIGNED_EN
            neg_d    = a_i[WIDTH-1] ^ b_i[WIDTH-1];
`endif
        end else if (step_i) begin
            acc_d    = sum_s[WIDTH:1];
            mplier_d = {sum_s[0], mplier_q[WIDTH-1:1]};
        end else begin
            acc_d    = acc_q;
        end
`ifdef MUL_SIGNED_EN
        if (fix_i) begin
            p_d = neg_q ? ({(2*WIDTH){1'b0}} - {acc_q, mplier_q}) : {acc_q, mplier_q};
        end else begin
            p_d = p_q;
        end
`else
        if (step_i && last_i) begin
            p_d = {acc_d, mplier_d};
        end else begin
            p_d = p_q;
        end
`endif
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            p_q      <= {(2*WIDTH){1'b0}};
`ifdef MUL_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            p_q      <= p_d;
`ifdef MUL_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier top: handshake FSM driving mul_seq_dp.
// Define MUL_SIGNED_EN for two's complement operands (adds a FIX state).
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, out_valid_q;
    logic             load_s, step_s, last_s;
`ifdef MUL_SIGNED_EN
    logic             fix_s;
`endif

    // Next-state, counter and datapath strobes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_s  = 1'b0;
        step_s  = 1'b0;
        last_s  = 1'b0;
`ifdef MUL_SIGNED_EN
        fix_s   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    load_s  = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                step_s = 1'b1;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    last_s = 1'b1;
`ifdef MUL_SIGNED_EN
                    state_d = ST_FIX;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_CALC;
                end
            end
`ifdef MUL_SIGNED_EN
            ST_FIX: begin
                fix_s   = 1'b1;
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

    mul_seq_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_s),
        .step_i (step_s),
`ifdef MUL_SIGNED_EN
        .fix_i  (fix_s),
`else
        .last_i (last_s),
`endif
        .a_i    (a),
        .b_i    (b),
        .p_o    (p)
    );

`ifdef MUL_SIGNED_EN
    logic unused_last_s;
    assign unused_last_s = last_s;
`endif

endmodule
